// File: rtl/multicycle_proc_if.sv
// Shared memory port of the multi-cycle core.
// One req/ready channel carries both instruction fetches and data loads and stores.
//   mem_req   : access request, driven by the core
//   mem_we    : 1 = store, 0 = read
//   mem_addr  : word-aligned byte address
//   mem_wdata : store data
//   mem_rdata : read data, valid while mem_ready is high
//   mem_ready : the access completes at the next rising edge
// The master modport belongs to the core; the slave modport belongs to the memory model.
interface multicycle_proc_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_proc.sv
// Multi-cycle MIPS-subset core: add/sub/and/or/slt, addi/ori, lw/sw, beq and j.
// A FETCH/DECODE/EXEC/MEM/WB/HALT state machine sequences each instruction.
// All fetch and data traffic goes through one shared req/ready memory port.
//   CLK     : rising-edge clock
//   Reset   : synchronous, active-high reset
//   startPC : PC value loaded while Reset is high
//   mem     : shared memory port (master side)
//   dmemOut : last register-file write value, or the last store data
//   retire  : one-cycle pulse in the cycle after an instruction finishes
//   halted  : the core is in HALT
module multicycle_proc #(
  parameter int ADDR_W       = 32,
  parameter bit ILLEGAL_HALT = 1'b1,
  parameter bit TRAP_ON_OVF  = 1'b0
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [ADDR_W-1:0]   startPC,
  multicycle_proc_if.master   mem,
  output logic [31:0]         dmemOut,
  output logic                retire,
  output logic                halted
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q, regA_q, regB_q, result_q, dmemOut_q;
  logic              retire_q, retire_d, run_q;
  logic [31:0]       regFile_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rsIdx, rtIdx, rdIdx, destIdx;
  logic [31:0] immSext, immZext, memAddrCalc, aluRes;
  logic        isRType, isLw, isSw, isBeq, isJ, memOp;
  logic        legalOp, overflow, illegal;

  assign opcode      = instr_q[31:26];
  assign rsIdx       = instr_q[25:21];
  assign rtIdx       = instr_q[20:16];
  assign rdIdx       = instr_q[15:11];
  assign funct       = instr_q[5:0];
  assign immSext     = {{16{instr_q[15]}}, instr_q[15:0]};
  assign immZext     = {16'h0000, instr_q[15:0]};
  assign isRType     = (opcode == 6'd0);
  assign isLw        = (opcode == 6'd35);
  assign isSw        = (opcode == 6'd43);
  assign isBeq       = (opcode == 6'd4);
  assign isJ         = (opcode == 6'd2);
  assign memOp       = isLw | isSw;
  assign destIdx     = isRType ? rdIdx : rtIdx;
  assign memAddrCalc = regA_q + immSext;
  assign illegal     = !legalOp || (memOp && (memAddrCalc[1:0] != 2'b00));

  // ALU and instruction legality. Overflow is the usual signed rule: the
  // operands agree in sign (after negating the subtrahend) but the result does not.
  always_comb begin
    aluRes   = 32'h0000_0000;
    overflow = 1'b0;
    legalOp  = 1'b1;
    if (isRType) begin
      case (funct)
        6'd32: begin
          aluRes   = regA_q + regB_q;
          overflow = (regA_q[31] == regB_q[31]) && (aluRes[31] != regA_q[31]);
        end
        6'd34: begin
          aluRes   = regA_q - regB_q;
          overflow = (regA_q[31] != regB_q[31]) && (aluRes[31] != regA_q[31]);
        end
        6'd36:   aluRes = regA_q & regB_q;
        6'd37:   aluRes = regA_q | regB_q;
        6'd42:   aluRes = {31'd0, $signed(regA_q) < $signed(regB_q)};
        default: legalOp = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'd8: begin
          aluRes   = regA_q + immSext;
          overflow = (regA_q[31] == immSext[31]) && (aluRes[31] != regA_q[31]);
        end
        6'd13:        aluRes = regA_q | immZext;
        6'd35, 6'd43: aluRes = memAddrCalc;
        6'd4, 6'd2:   aluRes = 32'h0000_0000;
        default:      legalOp = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. retire_d marks the last cycle of an instruction, so the
  // registered retire pulse lands in the cycle after it. FETCH waits for run_q
  // so that no request is issued in the cycle right after a reset edge.
  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    case (state_q)
      FETCH: begin
        if (run_q && mem.mem_ready) state_d = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (illegal) begin
          state_d  = ILLEGAL_HALT ? HALT : FETCH;
          retire_d = !ILLEGAL_HALT;
        end else if (memOp) begin
          state_d = MEM;
        end else if (isBeq || isJ) begin
          state_d  = FETCH;
          retire_d = 1'b1;
        end else if (TRAP_ON_OVF && overflow) begin
          state_d = HALT;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (mem.mem_ready) begin
          state_d  = isSw ? FETCH : WB;
          retire_d = isSw;
        end
      end
      WB: begin
        state_d  = FETCH;
        retire_d = 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // Datapath registers. result_q doubles as the memory data register: lw
  // captures its read data there, and WB writes result_q for both ALU ops and loads.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q      <= startPC;
      instr_q   <= '0;
      regA_q    <= '0;
      regB_q    <= '0;
      result_q  <= '0;
      dmemOut_q <= '0;
      retire_q  <= 1'b0;
      run_q     <= 1'b0;
      for (int i = 0; i < 32; i++) regFile_q[i] <= '0;
    end else begin
      run_q    <= 1'b1;
      retire_q <= retire_d;
      case (state_q)
        FETCH: begin
          if (run_q && mem.mem_ready) begin
            instr_q <= mem.mem_rdata;
            pc_q    <= pc_q + ADDR_W'(4);
          end
        end
        DECODE: begin
          regA_q <= regFile_q[rsIdx];
          regB_q <= regFile_q[rtIdx];
        end
        EXEC: begin
          result_q <= aluRes;
          if (!illegal && isBeq && (regA_q == regB_q)) begin
            pc_q <= pc_q + ADDR_W'($signed({immSext[29:0], 2'b00}));
          end else if (!illegal && isJ) begin
            pc_q <= (pc_q & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({instr_q[25:0], 2'b00});
          end
        end
        MEM: begin
          if (mem.mem_ready) begin
            if (isSw) dmemOut_q <= regB_q;
            else      result_q  <= mem.mem_rdata;
          end
        end
        WB: begin
          if (destIdx != 5'd0) regFile_q[destIdx] <= result_q;
          dmemOut_q <= result_q;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req   = run_q && ((state_q == FETCH) || (state_q == MEM));
  assign mem.mem_we    = (state_q == MEM) && isSw;
  assign mem.mem_addr  = (state_q == MEM) ? ADDR_W'(memAddrCalc) : pc_q;
  assign mem.mem_wdata = regB_q;
  assign dmemOut       = dmemOut_q;
  assign retire        = retire_q;
  assign halted        = (state_q == HALT);

endmodule

// File: tb/tb_multicycle_proc.sv
// Directed bench for multicycle_proc.
// dut0 (TRAP_ON_OVF=0) runs the main program at 0x40: ALU ops, store/load with
// two wait states, a branch loop, a wrapping overflow and an illegal opcode.
// dut1 (TRAP_ON_OVF=1) runs a short program at 0x80 that traps on overflow.
// Both cores share one memory array. Addresses at or above 0x100 take WAIT_DATA
// wait states; instruction fetches below 0x100 complete without waiting.
module tb_multicycle_proc;

  localparam int WAIT_DATA = 2;

  logic        CLK = 1'b0;
  logic        Reset, Reset1;
  logic [31:0] startPC0, startPC1;
  logic [31:0] dmemOut0, dmemOut1;
  logic        retire0, retire1, halted0, halted1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wait0  = 0;
  int wait1  = 0;

  logic [31:0] mem [0:127];
  logic [31:0] fetchLog [$];

  multicycle_proc_if #(.ADDR_W(32)) bus0 ();
  multicycle_proc_if #(.ADDR_W(32)) bus1 ();

  multicycle_proc #(.ADDR_W(32), .ILLEGAL_HALT(1'b1), .TRAP_ON_OVF(1'b0)) dut0 (
    .CLK(CLK), .Reset(Reset), .startPC(startPC0), .mem(bus0),
    .dmemOut(dmemOut0), .retire(retire0), .halted(halted0)
  );

  multicycle_proc #(.ADDR_W(32), .ILLEGAL_HALT(1'b1), .TRAP_ON_OVF(1'b1)) dut1 (
    .CLK(CLK), .Reset(Reset1), .startPC(startPC1), .mem(bus1),
    .dmemOut(dmemOut1), .retire(retire1), .halted(halted1)
  );

  always #5 CLK = ~CLK;

  // Cycle counter used to measure instruction latencies.
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model. ready is combinational so a zero-wait access completes in
  // its first request cycle; the wait counters restart whenever a request ends.
  assign bus0.mem_ready = bus0.mem_req && ((bus0.mem_addr < 32'h100) || (wait0 >= WAIT_DATA));
  assign bus1.mem_ready = bus1.mem_req && ((bus1.mem_addr < 32'h100) || (wait1 >= WAIT_DATA));
  assign bus0.mem_rdata = mem[bus0.mem_addr[8:2]];
  assign bus1.mem_rdata = mem[bus1.mem_addr[8:2]];

  always @(posedge CLK) begin
    wait0 <= (bus0.mem_req && !bus0.mem_ready) ? wait0 + 1 : 0;
    wait1 <= (bus1.mem_req && !bus1.mem_ready) ? wait1 + 1 : 0;
    if (bus0.mem_req && bus0.mem_ready && bus0.mem_we) mem[bus0.mem_addr[8:2]] <= bus0.mem_wdata;
    if (bus1.mem_req && bus1.mem_ready && bus1.mem_we) mem[bus1.mem_addr[8:2]] <= bus1.mem_wdata;
  end

  // Record every completed instruction fetch of dut0 to trace the branch loop.
  always @(negedge CLK) begin
    if (bus0.mem_req && bus0.mem_ready && !bus0.mem_we && (bus0.mem_addr < 32'h100))
      fetchLog.push_back(bus0.mem_addr);
  end

  function automatic logic [31:0] iEnc(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rEnc(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic loadWord(input logic [31:0] a, input logic [31:0] w);
    mem[a[8:2]] <= w;
  endtask

  // Every comparison of the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Wait (bounded) for the next retire pulse of dut0 and return its cycle.
  task automatic waitRetire(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 200 && at < 0; i++) begin
      @(negedge CLK);
      if (retire0) at = cyc;
    end
    checkOutput(tag, (at >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Program images and initial input values.
  task automatic applyStimulus();
    Reset    = 1'b1;
    Reset1   = 1'b1;
    startPC0 = 32'h40;
    startPC1 = 32'h80;
    for (int i = 0; i < 128; i++) mem[i] <= '0;
    loadWord(32'h40, iEnc(6'd8, 5'd0, 5'd1, 16'd5));        // addi $1,$0,5
    loadWord(32'h44, iEnc(6'd8, 5'd0, 5'd2, 16'd7));        // addi $2,$0,7
    loadWord(32'h48, rEnc(5'd1, 5'd2, 5'd3, 6'd32));        // add  $3,$1,$2
    loadWord(32'h4C, iEnc(6'd43, 5'd0, 5'd3, 16'h0100));    // sw   $3,0x100($0)
    loadWord(32'h50, iEnc(6'd35, 5'd0, 5'd4, 16'h0100));    // lw   $4,0x100($0)
    loadWord(32'h54, rEnc(5'd4, 5'd4, 5'd6, 6'd32));        // add  $6,$4,$4
    loadWord(32'h58, iEnc(6'd8, 5'd0, 5'd1, 16'd3));        // addi $1,$0,3
    loadWord(32'h5C, iEnc(6'd8, 5'd1, 5'd1, 16'hFFFF));     // loop: addi $1,$1,-1
    loadWord(32'h60, iEnc(6'd4, 5'd1, 5'd0, 16'd1));        // beq  $1,$0,+1
    loadWord(32'h64, {6'd2, 26'h17});                       // j    loop (0x5C)
    loadWord(32'h68, iEnc(6'd13, 5'd1, 5'd7, 16'h0055));    // ori  $7,$1,0x55
    loadWord(32'h6C, iEnc(6'd35, 5'd0, 5'd8, 16'h0108));    // lw   $8,0x108($0)
    loadWord(32'h70, iEnc(6'd8, 5'd0, 5'd9, 16'd1));        // addi $9,$0,1
    loadWord(32'h74, rEnc(5'd8, 5'd9, 5'd10, 6'd32));       // add  $10,$8,$9
    loadWord(32'h78, 32'hFC00_0000);                        // opcode 63
    loadWord(32'h80, iEnc(6'd35, 5'd0, 5'd8, 16'h0108));    // lw   $8,0x108($0)
    loadWord(32'h84, iEnc(6'd8, 5'd0, 5'd9, 16'd1));        // addi $9,$0,1
    loadWord(32'h88, iEnc(6'd8, 5'd0, 5'd10, 16'h0033));    // addi $10,$0,0x33
    loadWord(32'h8C, rEnc(5'd8, 5'd9, 5'd10, 6'd32));       // add  $10,$8,$9
    loadWord(32'h108, 32'h7FFF_FFFF);
  endtask

  initial begin
    int          fetchStart, lwStart, t1, t2, t3, t4, tx, holdCnt, n60, n64, n68, last60, cnt1;
    int          tl [8];
    logic        found, stable, reqSeen;
    logic [31:0] acc;

    applyStimulus();
    repeat (2) @(posedge CLK);
    @(negedge CLK);

    // Reset state.
    checkOutput("resetReq", bus0.mem_req, 1'b0);
    checkOutput("resetHalted", halted0, 1'b0);
    checkOutput("resetRetire", retire0, 1'b0);
    checkOutput("resetDmem", dmemOut0, 32'h0);
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut0.regFile_q[i];
    checkOutput("resetRegs", acc, 32'h0);

    Reset = 1'b0;
    @(negedge CLK);
    checkOutput("firstReq", bus0.mem_req, 1'b1);
    checkOutput("firstAddr", bus0.mem_addr, 32'h40);
    checkOutput("firstWe", bus0.mem_we, 1'b0);
    fetchStart = cyc;

    // Three ALU instructions, 4 cycles each.
    waitRetire("retireAddi1", t1);
    checkOutput("addi1Dmem", dmemOut0, 32'd5);
    checkOutput("aluLatency", t1 - fetchStart, 32'd4);
    waitRetire("retireAddi2", t2);
    checkOutput("addi2Dmem", dmemOut0, 32'd7);
    checkOutput("retireGap1", t2 - t1, 32'd4);
    waitRetire("retireAdd", t3);
    checkOutput("addDmem", dmemOut0, 32'd12);
    checkOutput("retireGap2", t3 - t2, 32'd4);

    // Store with two wait states: request held stable for three cycles.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge CLK);
      if (bus0.mem_req && bus0.mem_we) found = 1'b1;
    end
    checkOutput("swSeen", found, 1'b1);
    checkOutput("swAddr", bus0.mem_addr, 32'h100);
    checkOutput("swData", bus0.mem_wdata, 32'd12);
    holdCnt = 0;
    stable  = 1'b1;
    while (bus0.mem_req && bus0.mem_we && holdCnt < 10) begin
      if (bus0.mem_addr !== 32'h100 || bus0.mem_wdata !== 32'd12) stable = 1'b0;
      holdCnt++;
      @(negedge CLK);
    end
    checkOutput("swHoldCycles", holdCnt, 32'd3);
    checkOutput("swStable", stable, 1'b1);
    checkOutput("swRetire", retire0, 1'b1);
    checkOutput("swDmem", dmemOut0, 32'd12);
    checkOutput("lwFetchAddr", bus0.mem_addr, 32'h50);
    lwStart = cyc;

    // Load with two wait states: retire 7 cycles after its fetch begins.
    waitRetire("retireLw", t4);
    checkOutput("lwLatency", t4 - lwStart, 32'd7);
    checkOutput("lwDmem", dmemOut0, 32'd12);
    waitRetire("retireAdd6", tx);
    checkOutput("add6Dmem", dmemOut0, 32'd24);

    // Branch loop.
    waitRetire("retireAddi3", tx);
    checkOutput("loopInitDmem", dmemOut0, 32'd3);
    for (int k = 0; k < 8; k++) waitRetire("retireLoop", tl[k]);
    checkOutput("beqLatency", tl[1] - tl[0], 32'd3);
    checkOutput("jLatency", tl[2] - tl[1], 32'd3);
    checkOutput("loopEndDmem", dmemOut0, 32'd0);
    waitRetire("retireOri", tx);
    checkOutput("oriDmem", dmemOut0, 32'h55);
    n60 = 0; n64 = 0; n68 = 0; last60 = -1;
    foreach (fetchLog[i]) begin
      if (fetchLog[i] == 32'h60) begin n60++; last60 = i; end
      if (fetchLog[i] == 32'h64) n64++;
      if (fetchLog[i] == 32'h68) n68++;
    end
    checkOutput("beqFetches", n60, 32'd3);
    checkOutput("jFetches", n64, 32'd2);
    checkOutput("takenOnce", n68, 32'd1);
    checkOutput("afterBeq", (last60 >= 0 && last60 + 1 < fetchLog.size()) ?
                fetchLog[last60 + 1] : 32'hDEAD_BEEF, 32'h68);

    // Wrapping overflow.
    waitRetire("retireLw8", tx);
    checkOutput("lw8Dmem", dmemOut0, 32'h7FFF_FFFF);
    waitRetire("retireAddi9", tx);
    checkOutput("addi9Dmem", dmemOut0, 32'd1);
    waitRetire("retireOvf", tx);
    checkOutput("ovfWrapDmem", dmemOut0, 32'h8000_0000);

    // Illegal opcode halts and stays quiet.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge CLK);
      if (halted0) found = 1'b1;
    end
    checkOutput("illegalHalts", found, 1'b1);
    reqSeen = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (bus0.mem_req) reqSeen = 1'b1;
    end
    checkOutput("haltNoReq", reqSeen, 1'b0);
    checkOutput("haltSticky", halted0, 1'b1);

    // Reset leaves HALT and fetching restarts at startPC.
    Reset = 1'b1;
    @(negedge CLK);
    checkOutput("rstReq", bus0.mem_req, 1'b0);
    checkOutput("rstHalted", halted0, 1'b0);
    Reset = 1'b0;
    @(negedge CLK);
    checkOutput("restartReq", bus0.mem_req, 1'b1);
    checkOutput("restartAddr", bus0.mem_addr, 32'h40);

    // Trapping core: overflow halts with no writeback.
    Reset1 = 1'b0;
    cnt1 = 0;
    for (int i = 0; i < 200 && cnt1 < 3; i++) begin
      @(negedge CLK);
      if (retire1) cnt1++;
    end
    checkOutput("trapRetires", cnt1, 32'd3);
    checkOutput("trapPreDmem", dmemOut1, 32'h33);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge CLK);
      if (halted1) found = 1'b1;
    end
    checkOutput("trapHalts", found, 1'b1);
    checkOutput("trapDestKept", dut1.regFile_q[10], 32'h33);
    checkOutput("trapDmemKept", dmemOut1, 32'h33);
    checkOutput("trapNoReq", bus1.mem_req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
